// File: rtl/sequence_counter_if.sv
// Control/status bundle between the sequencer and the sequence counter.
// master drives the control pulses; slave returns the counter state.
interface sequence_counter_if #(
  parameter int SC_W = 3
) ();

  logic            start;
  logic            hlt;
  logic            clr;
  logic            inr;
  logic            step;
  logic [SC_W-1:0] sc_value;
  logic            running;
  logic            sc_wrap;

  modport master (
    output start,
    output hlt,
    output clr,
    output inr,
    output step,
    input  sc_value,
    input  running,
    input  sc_wrap
  );

  modport slave (
    input  start,
    input  hlt,
    input  clr,
    input  inr,
    input  step,
    output sc_value,
    output running,
    output sc_wrap
  );

endinterface

// File: rtl/sequence_counter.sv
// Sequence counter with STOP/RUN control (S flip-flop) feeding a 3-to-8 timing decoder.
// Optional macro SC_OVERFLOW_TRAP_EN: a counter wrap while running also halts.
module sequence_counter #(
  parameter bit RESET_RUN = 1'b0,
  parameter int SC_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sequence_counter_if.slave bus
);

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [SC_W-1:0] CNT_MAX = '1;

  state_t          state;
  logic [SC_W-1:0] count;
  logic            wrap;
  logic            run_q;

  state_t          state_nx;
  logic [SC_W-1:0] count_nx;
  logic            wrap_nx;
  logic            bump;
  logic            at_max;

  assign at_max = (count == CNT_MAX);

  // Next-state and counter update: hlt beats everything in RUN, clr beats increments.
  always_comb begin
    state_nx = state;
    count_nx = count;
    wrap_nx  = 1'b0;
    bump     = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.hlt) begin
          state_nx = STOP;
          count_nx = '0;
        end else if (bus.clr) begin
          count_nx = '0;
        end else if (bus.inr) begin
          bump = 1'b1;
        end
      end
      STOP: begin
        if (bus.start && !bus.hlt) begin
          state_nx = RUN;
        end
        if (bus.clr) begin
          count_nx = '0;
        end else if (bus.step) begin
          bump = 1'b1;
        end
      end
      default: begin
        state_nx = STOP;
      end
    endcase
    if (bump) begin
      count_nx = count + 1'b1;
      wrap_nx  = at_max;
`ifdef SC_OVERFLOW_TRAP_EN
      if (at_max && (state == RUN)) begin
        state_nx = STOP;
      end
`else
      state_nx = state_nx;
`endif
    end
  end

  // Register state, counter and all outputs; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RESET_RUN ? RUN : STOP;
      run_q <= RESET_RUN;
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      run_q <= (state_nx == RUN);
      count <= count_nx;
      wrap  <= wrap_nx;
    end
  end

  assign bus.sc_value = count;
  assign bus.running  = run_q;
  assign bus.sc_wrap  = wrap;

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench for sequence_counter: directed scenarios then random traffic,
// two instances (RESET_RUN=0 and 1) compared against an arithmetic reference model.
module tb_sequence_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic start, hlt, clr, inr, step;

  int n_assert = 0;
  int n_fail   = 0;

  int m_cnt  [2];
  bit m_run  [2];
  bit m_wrap [2];

`ifdef SC_OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  sequence_counter_if #(.SC_W(3)) bus0 ();
  sequence_counter_if #(.SC_W(3)) bus1 ();

  assign bus0.start = start;
  assign bus0.hlt   = hlt;
  assign bus0.clr   = clr;
  assign bus0.inr   = inr;
  assign bus0.step  = step;
  assign bus1.start = start;
  assign bus1.hlt   = hlt;
  assign bus1.clr   = clr;
  assign bus1.inr   = inr;
  assign bus1.step  = step;

  sequence_counter #(.RESET_RUN(1'b0), .SC_W(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  sequence_counter #(.RESET_RUN(1'b1), .SC_W(3)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: one clock of the architectural rules, in plain arithmetic.
  task automatic model_step(input int i);
    bit clear, incr, was_run;
    was_run = m_run[i];
    if (!rst_n) begin
      m_run[i]  = (i == 1);
      m_cnt[i]  = 0;
      m_wrap[i] = 1'b0;
      return;
    end
    clear = clr || (was_run && hlt);
    incr  = !clear && (was_run ? inr : step);
    m_wrap[i] = incr && (m_cnt[i] + 1 == 8);
    if (clear)     m_cnt[i] = 0;
    else if (incr) m_cnt[i] = (m_cnt[i] + 1) % 8;
    if (was_run) begin
      if (hlt) m_run[i] = 1'b0;
      else if (TRAP && m_wrap[i]) m_run[i] = 1'b0;
    end else if (start && !hlt) begin
      m_run[i] = 1'b1;
    end
  endtask

  task automatic cycle(input string tag);
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    chk({tag, "_cnt0"},  int'(bus0.sc_value), m_cnt[0]);
    chk({tag, "_run0"},  int'(bus0.running),  int'(m_run[0]));
    chk({tag, "_wrap0"}, int'(bus0.sc_wrap),  int'(m_wrap[0]));
    chk({tag, "_cnt1"},  int'(bus1.sc_value), m_cnt[1]);
    chk({tag, "_run1"},  int'(bus1.running),  int'(m_run[1]));
    chk({tag, "_wrap1"}, int'(bus1.sc_wrap),  int'(m_wrap[1]));
  endtask

  task automatic idle();
    start = 0; hlt = 0; clr = 0; inr = 0; step = 0;
  endtask

  initial begin
    m_cnt  = '{0, 0};
    m_run  = '{1'b0, 1'b0};
    m_wrap = '{1'b0, 1'b0};
    rst_n = 1'b0;
    idle();
    start = 1; hlt = 1; inr = 1;
    cycle("rst_a");
    cycle("rst_b");
    chk("rst_run0", int'(bus0.running), 0);
    chk("rst_run1", int'(bus1.running), 1);
    chk("rst_cnt0", int'(bus0.sc_value), 0);

    rst_n = 1'b1;
    idle();
    start = 1;
    cycle("start");
    chk("start_run0", int'(bus0.running), 1);
    chk("start_cnt0", int'(bus0.sc_value), 0);
    idle();
    inr = 1;
    for (int k = 1; k <= 3; k++) begin
      cycle("count");
      chk("count_val", int'(bus0.sc_value), k);
      chk("count_wrap", int'(bus0.sc_wrap), 0);
    end

    cycle("to5a");
    cycle("to5b");
    clr = 1;
    cycle("clrpri");
    chk("clrpri_cnt", int'(bus0.sc_value), 0);
    chk("clrpri_run", int'(bus0.running), 1);

    idle();
    inr = 1;
    for (int k = 0; k < 7; k++) cycle("to7");
    chk("pre_wrap_cnt", int'(bus0.sc_value), 7);
    cycle("wrap");
    chk("wrap_cnt", int'(bus0.sc_value), 0);
    chk("wrap_pulse", int'(bus0.sc_wrap), 1);
    chk("wrap_run", int'(bus0.running), TRAP ? 0 : 1);
    idle();
    cycle("wrap_end");
    chk("wrap_end", int'(bus0.sc_wrap), 0);

    clr = 1; start = 1;
    cycle("rerun");
    idle();
    inr = 1;
    for (int k = 0; k < 3; k++) cycle("to3");
    chk("pre_hlt_cnt", int'(bus0.sc_value), 3);
    idle();
    hlt = 1; start = 1;
    cycle("hlt_start");
    chk("hlt_run", int'(bus0.running), 0);
    chk("hlt_cnt", int'(bus0.sc_value), 0);
    idle();
    inr = 1;
    cycle("stop_inr");
    chk("stop_inr", int'(bus0.sc_value), 0);

    idle();
    step = 1;
    for (int k = 0; k < 7; k++) cycle("step7");
    chk("step7", int'(bus0.sc_value), 7);
    cycle("stepwrap");
    chk("stepwrap_cnt", int'(bus0.sc_value), 0);
    chk("stepwrap_pulse", int'(bus0.sc_wrap), 1);
    chk("stepwrap_run", int'(bus0.running), 0);
    cycle("step1");
    clr = 1;
    cycle("stepclr");
    chk("stepclr_cnt", int'(bus0.sc_value), 0);
    chk("stepclr_wrap", int'(bus0.sc_wrap), 0);

    idle();
    start = 1;
    cycle("run2");
    idle();
    inr = 1;
    for (int k = 0; k < 4; k++) cycle("to4");
    chk("pre_rst_cnt", int'(bus0.sc_value), 4);
    rst_n = 1'b0;
    cycle("midrst");
    chk("midrst_cnt0", int'(bus0.sc_value), 0);
    chk("midrst_wrap0", int'(bus0.sc_wrap), 0);
    chk("midrst_run0", int'(bus0.running), 0);
    chk("midrst_run1", int'(bus1.running), 1);
    rst_n = 1'b1;
    idle();

    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      start = ($urandom_range(0, 7) == 0);
      hlt   = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 9) == 0);
      inr   = ($urandom_range(0, 3) != 0);
      step  = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
